// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle control FSM: opcode table, exec commands,
// state encoding and instruction classes used by the decoder and the sequencer.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] EXE_ADD  = 4'd0;
    localparam logic [3:0] EXE_SUB  = 4'd2;
    localparam logic [3:0] EXE_AND  = 4'd4;
    localparam logic [3:0] EXE_OR   = 4'd5;
    localparam logic [3:0] EXE_NOR  = 4'd6;
    localparam logic [3:0] EXE_XOR  = 4'd7;
    localparam logic [3:0] EXE_SLL  = 4'd8;
    localparam logic [3:0] EXE_SRL  = 4'd9;
    localparam logic [3:0] EXE_PASS = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_IMM = 3'd2,
        CLS_LD  = 3'd3,
        CLS_ST  = 3'd4,
        CLS_BR  = 3'd5,
        CLS_JMP = 3'd6
    } op_class_e;

endpackage

// File: rtl/multicycle_control_fsm_opcode_decoder.sv
// Combinational opcode decode: exec command, immediate/branch flags, instruction
// class and illegal flag. Unknown opcodes decode as NOP with the illegal flag set.
module opcode_decoder
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int EXE_CMD_W = 4
) (
    input  logic [OPCODE_W-1:0]  i_opcode,
    output logic [EXE_CMD_W-1:0] o_exec_command,
    output logic                 o_is_immediate,
    output logic                 o_branch_type,
    output op_class_e            o_class,
    output logic                 o_illegal
);

    logic       w_upper_zero;
    logic [5:0] w_op;
    logic [3:0] w_exe;

    assign w_upper_zero = ((i_opcode >> 6) == '0);
    assign w_op         = i_opcode[5:0];

    always_comb begin
        w_exe          = EXE_PASS;
        o_is_immediate = 1'b0;
        o_branch_type  = 1'b0;
        o_class        = CLS_NOP;
        o_illegal      = 1'b0;
        case (w_op)
            OP_NOP:  o_class = CLS_NOP;
            OP_ADD:  begin w_exe = EXE_ADD; o_class = CLS_ALU; end
            OP_SUB:  begin w_exe = EXE_SUB; o_class = CLS_ALU; end
            OP_AND:  begin w_exe = EXE_AND; o_class = CLS_ALU; end
            OP_OR:   begin w_exe = EXE_OR;  o_class = CLS_ALU; end
            OP_NOR:  begin w_exe = EXE_NOR; o_class = CLS_ALU; end
            OP_XOR:  begin w_exe = EXE_XOR; o_class = CLS_ALU; end
            OP_SLL:  begin w_exe = EXE_SLL; o_class = CLS_ALU; end
            OP_SRL:  begin w_exe = EXE_SRL; o_class = CLS_ALU; end
            OP_ADDI: begin w_exe = EXE_ADD; o_is_immediate = 1'b1; o_class = CLS_IMM; end
            OP_SUBI: begin w_exe = EXE_SUB; o_is_immediate = 1'b1; o_class = CLS_IMM; end
            // address generation for loads/stores is an ADD of base + offset
            OP_LD:   begin w_exe = EXE_ADD; o_is_immediate = 1'b1; o_class = CLS_LD; end
            OP_ST:   begin w_exe = EXE_ADD; o_is_immediate = 1'b1; o_class = CLS_ST; end
            OP_BEZ:  begin w_exe = EXE_SUB; o_branch_type = 1'b1; o_class = CLS_BR; end
            OP_BNE:  begin w_exe = EXE_SUB; o_branch_type = 1'b1; o_class = CLS_BR; end
            OP_JMP:  o_class = CLS_JMP;
            default: o_illegal = 1'b1;
        endcase
        if (!w_upper_zero) begin
            w_exe          = EXE_PASS;
            o_is_immediate = 1'b0;
            o_branch_type  = 1'b0;
            o_class        = CLS_NOP;
            o_illegal      = 1'b1;
        end
    end

    assign o_exec_command = EXE_CMD_W'(w_exe);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with a per-access wait-cycle timeout that parks the FSM in ERROR until reset.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int EXE_CMD_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic [EXE_CMD_W-1:0] exec_command,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_enable,
    output logic                 is_immediate,
    output logic                 branch_type,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 ir_write,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic                 mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e                r_state;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic [EXE_CMD_W-1:0]  w_dec_exec;
    logic                  w_dec_imm;
    logic                  w_dec_branch;
    logic                  w_dec_illegal;
    op_class_e             w_dec_class;
    logic                  w_access;
    logic                  w_timeout;

    opcode_decoder #(
        .OPCODE_W  (OPCODE_W),
        .EXE_CMD_W (EXE_CMD_W)
    ) u_opcode_decoder (
        .i_opcode       (r_opcode),
        .o_exec_command (w_dec_exec),
        .o_is_immediate (w_dec_imm),
        .o_branch_type  (w_dec_branch),
        .o_class        (w_dec_class),
        .o_illegal      (w_dec_illegal)
    );

    assign w_access  = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
    // the limit cycle is the one that would push the wait count to MEM_TIMEOUT
    assign w_timeout = (MEM_TIMEOUT != 0) && w_access && !mem_ready &&
                       (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_opcode   <= OPCODE_W'(OP_NOP);
            r_wait_cnt <= '0;
        end else begin
            if (w_access && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;

            case (r_state)
                ST_FETCH: begin
                    if (mem_ready)
                        r_state <= ST_DECODE;
                    else if (w_timeout)
                        r_state <= ST_ERROR;
                end
                ST_DECODE: begin
                    r_opcode <= opcode;
                    r_state  <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    case (w_dec_class)
                        CLS_ALU, CLS_IMM: r_state <= ST_WRITEBACK;
                        CLS_LD, CLS_ST:   r_state <= ST_MEMORY;
                        default:          r_state <= ST_FETCH;
                    endcase
                end
                ST_MEMORY: begin
                    if (mem_ready)
                        r_state <= (w_dec_class == CLS_LD) ? ST_WRITEBACK : ST_FETCH;
                    else if (w_timeout)
                        r_state <= ST_ERROR;
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_ERROR:     r_state <= ST_ERROR;
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        exec_command = EXE_CMD_W'(EXE_PASS);
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        wb_enable    = 1'b0;
        is_immediate = 1'b0;
        branch_type  = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ir_write     = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        mem_err      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_EXECUTE: begin
                    exec_command = w_dec_exec;
                    is_immediate = w_dec_imm;
                    branch_type  = w_dec_branch;
                    illegal_op   = w_dec_illegal;
                    case (w_dec_class)
                        CLS_BR: begin
                            pc_write   = branch_taken;
                            pc_src     = branch_taken;
                            instr_done = 1'b1;
                        end
                        CLS_JMP: begin
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            instr_done = 1'b1;
                        end
                        CLS_NOP: instr_done = 1'b1;
                        default: instr_done = 1'b0;
                    endcase
                end
                ST_MEMORY: begin
                    mem_read   = (w_dec_class == CLS_LD);
                    mem_write  = (w_dec_class == CLS_ST);
                    instr_done = (w_dec_class == CLS_ST) && mem_ready;
                end
                ST_WRITEBACK: begin
                    wb_enable  = 1'b1;
                    instr_done = 1'b1;
                end
                ST_ERROR: mem_err = 1'b1;
                default: mem_err = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter OPCODE_W, default 6: opcode width; opcodes outside the package table are illegal.
REQ-002 Parameter EXE_CMD_W, default 4: exec_command width; must be at least 4.
REQ-003 Parameter MEM_TIMEOUT, default 15: wait-cycle limit per memory access; 0 disables the timeout.
REQ-004 Reset behaviour: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 opcode  in  OPCODE_W  instruction opcode from the IR; sampled only in DECODE.
REQ-008 mem_ready  in  1  memory has completed the current read or write.
REQ-009 branch_taken  in  1  datapath branch condition; valid in EXECUTE.
REQ-010 exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type  out  EXE_CMD_W/1/1/1/1/1  datapath controls.
REQ-011 pc_write, pc_src, ir_write  out  1 each  PC load, PC source (0 = PC+4, 1 = branch/jump target), IR load.
REQ-012 instr_done, illegal_op, mem_err  out  1 each  retire pulse, illegal-opcode pulse, sticky timeout error.

Function
REQ-013 States SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and ERROR.
REQ-014 FETCH: mem_read=1 while waiting; in the cycle mem_ready=1, ir_write=1 and pc_write=1 (pc_src=0), then DECODE.
REQ-015 DECODE: 1 cycle; latch opcode into an internal register; later states decode only the latched value.
REQ-016 EXECUTE: 1 cycle; exec_command and is_immediate driven from the latched opcode.
REQ-017 EXECUTE branch handling: BEZ/BNE set branch_type=1, with pc_write=pc_src=branch_taken; JMP sets pc_write=pc_src=1 unconditionally.
REQ-018 EXECUTE next state: ALU and immediate ops -> WRITEBACK; LD/ST -> MEMORY; branches, JMP, NOP and illegal -> FETCH with instr_done=1.
REQ-019 Illegal opcode: illegal_op=1 for the EXECUTE cycle; the instruction is treated as NOP.
REQ-020 MEMORY: LD drives mem_read=1 and ST drives mem_write=1 until mem_ready; then LD -> WRITEBACK, ST -> FETCH with instr_done=1.
REQ-021 WRITEBACK: wb_enable=1 and instr_done=1 for exactly 1 cycle, then FETCH.
REQ-022 Zero-wait latency: ALU/ADDI 4 cycles, LD 5, ST 4, branch/JMP/NOP 3.
REQ-023 Wait counter: a MEM_TIMEOUT-width-sufficient counter clears on entry to FETCH/MEMORY and increments each cycle without mem_ready.
REQ-024 Timeout: when the counter reaches MEM_TIMEOUT with mem_ready=0, next state is ERROR.
REQ-025 Ready on the limit: mem_ready=1 in the limit cycle completes the access normally.
REQ-026 ERROR: all controls 0; mem_err=1; the state is held until rst.
REQ-027 Controls are Moore decodes of state and latched opcode; only ir_write, pc_write and the MEMORY/FETCH exits are qualified by mem_ready or branch_taken.
REQ-028 Any control not explicitly asserted in a state is 0; exec_command defaults to EXE_PASS.

Reset
REQ-029 rst=1 at any clock edge, in any state including mid-wait or ERROR, forces FETCH, clears the counter, the latched opcode (to NOP) and mem_err.
REQ-030 All outputs are 0 during reset, except exec_command, which is EXE_PASS; fetch begins the cycle after rst falls.

Structure
REQ-031 A shared package holds the opcode constants: NOP 0, ADD 1, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLL 10, SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42.
REQ-032 The same package holds the exec constants (ADD 0, SUB 2, AND 4, OR 5, NOR 6, XOR 7, SLL 8, SRL 9, PASS 15) and the state encoding.
REQ-033 One sub-module, opcode_decoder (combinational, opcode -> exec_command, is_immediate, branch_type, class, illegal), is instantiated once.

Verification
REQ-034 ADD (1), mem_ready tied 1: states F,D,E,W; exec_command=0 in E; wb_enable and instr_done high on cycle 4 only.
REQ-035 LD (36), fetch ready after 2 waits, data ready after 3 waits: mem_read high 3 then 4 cycles; wb_enable on cycle 10; exec_command=0, is_immediate=1.
REQ-036 BEZ (40) run twice, branch_taken=1 then 0: first pc_write=pc_src=1 in E; second pc_write=0 in E; both retire in 3 cycles; JMP (42): pc_src=1 regardless of branch_taken.
REQ-037 Opcode 63: illegal_op=1 one cycle; no wb_enable, no memory access; next FETCH follows.
REQ-038 ST (37), mem_ready held 0: ERROR entered after 15 wait cycles; mem_err=1 and mem_write=0 thereafter; rst then restores FETCH with mem_err=0.
REQ-039 rst asserted in MEMORY mid-LD: next cycle is FETCH, wb_enable never asserted for that LD.
